jzjpcc_operandstage: RTL and testbench

Registered execute-stage operand selector for the jzjpcc pipelined RV32I core. It sits on the decode/execute boundary and resolves RS1/RS2 against a parametrised number of forwarding sources using priority. It generates a load-use hazard request and selects ALU operands A/B for six modes, including LUI. Held operands are refreshed from forwarding sources while the stage is stalled, so a stall never leaves stale data in execute.

---
 rtl/jzjpcc_operandstage_if.sv | 44 ++++
 rtl/jzjpcc_operandstage.sv | 170 +++++++++++++++++
 tb/tb_jzjpcc_operandstage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/jzjpcc_operandstage_if.sv
// Decode/execute boundary bus for the jzjpcc operand stage.
// Groups the decode-slot inputs, the forwarding sources, the stall/flush
// controls and the registered operand outputs.
//   master : producer side (decode, forwarding network, consumer of operands)
//   slave  : the operand stage itself
interface jzjpcc_operandstage_if #(
  parameter int PC_MAX_B   = 31,
  parameter int NUM_BYPASS = 3
);
  logic                      in_valid;
  logic [2:0]                aluMuxMode;
  logic                      storeOp;
  logic [4:0]                rs1Addr;
  logic [4:0]                rs2Addr;
  logic [31:0]               rs1;
  logic [31:0]               rs2;
  logic [31:0]               immediate;
  logic [PC_MAX_B-2:0]       currentPC;
  logic [NUM_BYPASS-1:0]     bypassValid;
  logic [5*NUM_BYPASS-1:0]   bypassAddr;
  logic [32*NUM_BYPASS-1:0]  bypassValue;
  logic [NUM_BYPASS-1:0]     bypassReady;
  logic                      stall;
  logic                      flush;
  logic                      out_valid;
  logic [31:0]               aluOperandA;
  logic [31:0]               aluOperandB;
  logic [31:0]               storeData;
  logic                      hazardStall;

  modport master (
    output in_valid, aluMuxMode, storeOp, rs1Addr, rs2Addr, rs1, rs2,
           immediate, currentPC, bypassValid, bypassAddr, bypassValue,
           bypassReady, stall, flush,
    input  out_valid, aluOperandA, aluOperandB, storeData, hazardStall
  );

  modport slave (
    input  in_valid, aluMuxMode, storeOp, rs1Addr, rs2Addr, rs1, rs2,
           immediate, currentPC, bypassValid, bypassAddr, bypassValue,
           bypassReady, stall, flush,
    output out_valid, aluOperandA, aluOperandB, storeData, hazardStall
  );
endinterface

// File: rtl/jzjpcc_operandstage.sv
// Registered execute-stage operand selector for the jzjpcc RV32I pipeline.
// Resolves RS1/RS2 against NUM_BYPASS forwarding sources (index 0 youngest,
// highest priority), raises a load-use hazard request, and registers the
// operands so the ALU sees them one cycle later. While stalled, held operand
// values keep snooping ready forwarding sources so execute never goes stale.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : jzjpcc_operandstage_if slave (decode inputs, forwarding sources,
//           stall/flush, operand outputs, hazardStall)
module jzjpcc_operandstage #(
  parameter int PC_MAX_B   = 31,
  parameter int NUM_BYPASS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  jzjpcc_operandstage_if.slave  bus
);

  localparam logic [2:0] MODE_RS1_RS2 = 3'b000;
  localparam logic [2:0] MODE_RS1_IMM = 3'b001;
  localparam logic [2:0] MODE_PC_4    = 3'b010;
  localparam logic [2:0] MODE_PC_IMM  = 3'b011;
  localparam logic [2:0] MODE_LUI     = 3'b100;
  localparam logic [2:0] MODE_RS1_0   = 3'b101;

  // Unpacked views of the flattened forwarding buses
  logic [4:0]  bp_addr  [NUM_BYPASS];
  logic [31:0] bp_value [NUM_BYPASS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYPASS; gi++) begin : g_bp_slice
      assign bp_addr[gi]  = bus.bypassAddr[5*gi +: 5];
      assign bp_value[gi] = bus.bypassValue[32*gi +: 32];
    end
  endgenerate

  // Registered execute fields
  logic                valid_reg;
  logic [2:0]          mode_reg;
  logic [PC_MAX_B-2:0] pc_reg;
  logic [31:0]         imm_reg;
  logic [4:0]          r1_addr_reg;
  logic [4:0]          r2_addr_reg;
  logic [31:0]         r1_val_reg;
  logic [31:0]         r2_val_reg;

  // Decode-side resolution: the winner's readiness matters even if a
  // lower-priority ready copy exists, so loop from the lowest priority up
  // and let younger matches overwrite.
  logic [31:0] rs1_res, rs2_res;
  logic        rs1_rdy, rs2_rdy;
  logic        rs1_used, rs2_used;
  logic        hazard;

  always_comb begin
    rs1_res = bus.rs1;
    rs1_rdy = 1'b1;
    rs2_res = bus.rs2;
    rs2_rdy = 1'b1;
    for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
      if (bus.bypassValid[i] && bp_addr[i] == bus.rs1Addr) begin
        rs1_res = bp_value[i];
        rs1_rdy = bus.bypassReady[i];
      end
      if (bus.bypassValid[i] && bp_addr[i] == bus.rs2Addr) begin
        rs2_res = bp_value[i];
        rs2_rdy = bus.bypassReady[i];
      end
    end
    if (bus.rs1Addr == 5'd0) begin
      rs1_res = 32'd0;
      rs1_rdy = 1'b1;
    end
    if (bus.rs2Addr == 5'd0) begin
      rs2_res = 32'd0;
      rs2_rdy = 1'b1;
    end
  end

  always_comb begin
    rs1_used = 1'b1;
    rs2_used = bus.storeOp;
    case (bus.aluMuxMode)
      MODE_PC_4, MODE_PC_IMM, MODE_LUI: rs1_used = 1'b0;
      default:                          rs1_used = 1'b1;
    endcase
    case (bus.aluMuxMode)
      MODE_RS1_IMM, MODE_PC_4, MODE_PC_IMM, MODE_LUI, MODE_RS1_0: ;
      default: rs2_used = 1'b1;
    endcase
  end

  // An external stall already holds upstream, so no hazard is reported then
  assign hazard = bus.in_valid && !bus.stall &&
                  ((rs1_used && !rs1_rdy) || (rs2_used && !rs2_rdy));
  assign bus.hazardStall = hazard;

  // Hold-side snooping: only ready sources can refresh a held value, so an
  // unready younger match is skipped in favour of an older ready one.
  logic        snoop1_hit, snoop2_hit;
  logic [31:0] snoop1_val, snoop2_val;

  always_comb begin
    snoop1_hit = 1'b0;
    snoop1_val = 32'd0;
    snoop2_hit = 1'b0;
    snoop2_val = 32'd0;
    for (int i = NUM_BYPASS - 1; i >= 0; i--) begin
      if (bus.bypassValid[i] && bus.bypassReady[i] && bp_addr[i] == r1_addr_reg) begin
        snoop1_hit = 1'b1;
        snoop1_val = bp_value[i];
      end
      if (bus.bypassValid[i] && bus.bypassReady[i] && bp_addr[i] == r2_addr_reg) begin
        snoop2_hit = 1'b1;
        snoop2_val = bp_value[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_reg   <= 1'b0;
      mode_reg    <= 3'b000;
      pc_reg      <= '0;
      imm_reg     <= 32'd0;
      r1_addr_reg <= 5'd0;
      r2_addr_reg <= 5'd0;
      r1_val_reg  <= 32'd0;
      r2_val_reg  <= 32'd0;
    end else if (bus.flush) begin
      valid_reg <= 1'b0;
    end else if (!bus.stall) begin
      valid_reg   <= bus.in_valid && !hazard;
      mode_reg    <= bus.aluMuxMode;
      pc_reg      <= bus.currentPC;
      imm_reg     <= bus.immediate;
      r1_addr_reg <= bus.rs1Addr;
      r2_addr_reg <= bus.rs2Addr;
      r1_val_reg  <= rs1_res;
      r2_val_reg  <= rs2_res;
    end else if (valid_reg) begin
      if (snoop1_hit && r1_addr_reg != 5'd0) r1_val_reg <= snoop1_val;
      if (snoop2_hit && r2_addr_reg != 5'd0) r2_val_reg <= snoop2_val;
    end
  end

  // Operand muxes
  logic [PC_MAX_B:0] pc_bytes;
  assign pc_bytes = {pc_reg, 2'b00};

  always_comb begin
    case (mode_reg)
      MODE_PC_4, MODE_PC_IMM: bus.aluOperandA = 32'(pc_bytes);
      MODE_LUI:               bus.aluOperandA = 32'd0;
      default:                bus.aluOperandA = r1_val_reg;
    endcase
    case (mode_reg)
      MODE_RS1_IMM, MODE_PC_IMM, MODE_LUI: bus.aluOperandB = imm_reg;
      MODE_PC_4:                           bus.aluOperandB = 32'd4;
      MODE_RS1_0:                          bus.aluOperandB = 32'd0;
      default:                             bus.aluOperandB = r2_val_reg;
    endcase
  end

  assign bus.out_valid = valid_reg;
  assign bus.storeData = r2_val_reg;

endmodule

// File: tb/tb_jzjpcc_operandstage.sv
// Directed-vector bench for jzjpcc_operandstage: priority resolution, x0,
// load-use hazard, snooping under stall, operand modes, flush and reset.
module tb_jzjpcc_operandstage;
  localparam int PC_MAX_B   = 31;
  localparam int NUM_BYPASS = 3;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  jzjpcc_operandstage_if #(.PC_MAX_B(PC_MAX_B), .NUM_BYPASS(NUM_BYPASS)) bus ();

  jzjpcc_operandstage #(.PC_MAX_B(PC_MAX_B), .NUM_BYPASS(NUM_BYPASS)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bp(input int idx, input logic v, input logic [4:0] a,
                        input logic [31:0] val, input logic rdy);
    bus.bypassValid[idx]         = v;
    bus.bypassAddr[5*idx +: 5]   = a;
    bus.bypassValue[32*idx +: 32] = val;
    bus.bypassReady[idx]         = rdy;
  endtask

  task automatic clear_bp();
    bus.bypassValid = '0;
    bus.bypassAddr  = '0;
    bus.bypassValue = '0;
    bus.bypassReady = '0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.aluMuxMode = 3'b000; bus.storeOp = 0;
    bus.rs1Addr = 0; bus.rs2Addr = 0; bus.rs1 = 0; bus.rs2 = 0;
    bus.immediate = 0; bus.currentPC = 0; bus.stall = 0; bus.flush = 0;
    clear_bp();
    #12;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_A", bus.aluOperandA, 32'd0);
    check("rst_B", bus.aluOperandB, 32'd0);
    check("rst_sd", bus.storeData, 32'd0);
    check("rst_haz", 32'(bus.hazardStall), 32'd0);
    step();
    rst_n = 1'b1;

    // Priority: bypass0 beats bypass1 for rs1; rs2 = x0 forced to zero
    bus.in_valid = 1; bus.aluMuxMode = 3'b000;
    bus.rs1Addr = 5; bus.rs1 = 32'h0000DEAD;
    bus.rs2Addr = 0; bus.rs2 = 32'h55;
    set_bp(0, 1, 5, 32'hAAAA0000, 1);
    set_bp(1, 1, 5, 32'h11111111, 1);
    #1 check("prio_haz", 32'(bus.hazardStall), 32'd0);
    step();
    check("prio_valid", 32'(bus.out_valid), 32'd1);
    check("prio_A", bus.aluOperandA, 32'hAAAA0000);
    check("x0_rs2_B", bus.aluOperandB, 32'd0);

    // Match on x0 is ignored
    bus.rs1Addr = 0; bus.rs1 = 32'h1234;
    set_bp(0, 1, 0, 32'hAAAA0000, 1);
    step();
    check("x0_A", bus.aluOperandA, 32'd0);

    // Load-use: unready winner blocks even with a ready older copy
    clear_bp();
    bus.rs2Addr = 7; bus.rs2 = 32'h0;
    set_bp(0, 1, 7, 32'h00000BAD, 0);
    set_bp(1, 1, 7, 32'h77777777, 1);
    #1 check("lu_haz", 32'(bus.hazardStall), 32'd1);
    step();
    check("lu_bubble", 32'(bus.out_valid), 32'd0);
    bus.bypassValid[0] = 1'b0;
    #1 check("lu_haz_clr", 32'(bus.hazardStall), 32'd0);
    step();
    check("lu_valid", 32'(bus.out_valid), 32'd1);
    check("lu_B", bus.aluOperandB, 32'h77777777);
    check("lu_sd", bus.storeData, 32'h77777777);

    // Store uses rs2 even in an imm mode; stall suppresses hazard report
    bus.aluMuxMode = 3'b001; bus.storeOp = 1;
    bus.bypassValid[0] = 1'b1;
    #1 check("st_haz", 32'(bus.hazardStall), 32'd1);
    bus.stall = 1;
    #1 check("stall_haz", 32'(bus.hazardStall), 32'd0);
    bus.stall = 0; bus.storeOp = 0;

    // Snoop under stall
    clear_bp();
    bus.aluMuxMode = 3'b001; bus.rs1Addr = 9; bus.rs1 = 32'd3;
    bus.rs2Addr = 0; bus.immediate = 32'h10;
    step();
    check("snp_A0", bus.aluOperandA, 32'd3);
    check("snp_B0", bus.aluOperandB, 32'h10);
    bus.stall = 1; bus.rs1 = 32'h999; bus.immediate = 32'h20;
    step();
    check("snp_A1", bus.aluOperandA, 32'd3);
    set_bp(2, 1, 9, 32'h12345678, 1);
    step();
    check("snp_A2", bus.aluOperandA, 32'h12345678);
    check("snp_valid2", 32'(bus.out_valid), 32'd1);
    clear_bp();
    step();
    check("snp_A3", bus.aluOperandA, 32'h12345678);
    check("snp_B3", bus.aluOperandB, 32'h10);
    check("snp_valid3", 32'(bus.out_valid), 32'd1);
    // unready younger match is skipped for the older ready one
    set_bp(0, 1, 9, 32'hDEADBEEF, 0);
    set_bp(1, 1, 9, 32'h0000CAFE, 1);
    step();
    check("snp_skip", bus.aluOperandA, 32'h0000CAFE);
    clear_bp();
    bus.stall = 0;

    // Modes
    bus.currentPC = 30'h100; bus.immediate = 32'hFFFFF000;
    bus.rs1Addr = 0; bus.rs2Addr = 0;
    bus.aluMuxMode = 3'b010; step();
    check("m010_A", bus.aluOperandA, 32'h400);
    check("m010_B", bus.aluOperandB, 32'd4);
    bus.aluMuxMode = 3'b011; step();
    check("m011_A", bus.aluOperandA, 32'h400);
    check("m011_B", bus.aluOperandB, 32'hFFFFF000);
    bus.aluMuxMode = 3'b100; bus.rs1Addr = 3; bus.rs1 = 32'h33; step();
    check("m100_A", bus.aluOperandA, 32'd0);
    check("m100_B", bus.aluOperandB, 32'hFFFFF000);
    bus.aluMuxMode = 3'b101; bus.rs2Addr = 4; bus.rs2 = 32'h44; step();
    check("m101_A", bus.aluOperandA, 32'h33);
    check("m101_B", bus.aluOperandB, 32'd0);
    bus.aluMuxMode = 3'b110; step();
    check("m110_A", bus.aluOperandA, 32'h33);
    check("m110_B", bus.aluOperandB, 32'h44);

    // Flush vs stall, flush vs load
    bus.flush = 1; bus.stall = 1; step();
    check("fl_stall", 32'(bus.out_valid), 32'd0);
    bus.flush = 0; bus.stall = 0; step();
    check("fl_resume", 32'(bus.out_valid), 32'd1);
    bus.flush = 1; step();
    check("fl_load", 32'(bus.out_valid), 32'd0);
    bus.flush = 0; step();
    check("fl_resume2", 32'(bus.out_valid), 32'd1);

    // Asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_A", bus.aluOperandA, 32'd0);
    check("arst_B", bus.aluOperandB, 32'd0);
    check("arst_sd", bus.storeData, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst", 32'(bus.out_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
